// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// boot_pkg : shared constants and state encoding for the UART boot loader
// Rev 1.0
// ============================================================================
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         LEN_W      = 16;
  localparam int         WORD_BYTES = 4;

  typedef logic [2:0] boot_state_t;

  localparam boot_state_t ST_IDLE  = 3'd0;
  localparam boot_state_t ST_LEN0  = 3'd1;
  localparam boot_state_t ST_LEN1  = 3'd2;
  localparam boot_state_t ST_DATA  = 3'd3;
  localparam boot_state_t ST_WRITE = 3'd4;
  localparam boot_state_t ST_CSUM  = 3'd5;
  localparam boot_state_t ST_DONE  = 3'd6;
  localparam boot_state_t ST_ERROR = 3'd7;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 receiver with double-flop input sync and mid-bit sampling
// Rev 1.0
// ============================================================================
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset_async,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [2:0]       sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             line;
  logic             fall;

  // sync[1] is the twice-registered line; sync[2] only serves edge detection
  assign line = sync[1];
  assign fall = sync[2] & ~sync[1];

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      sync         <= 3'b111;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[1:0], rxd};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            rx_data <= {line, rx_data[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            rx_valid     <= line;
            rx_frame_err <= ~line;
            state        <= RX_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// uart_boot_loader : serial image loader into program RAM, gates CPU reset
// Optional feature macro: BOOT_CHECKSUM_EN (trailing CSUM byte checked)
// Rev 1.0
// ============================================================================
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 15,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic              clk,
  input  logic              reset_async,
  input  logic              rs232_dce_rxd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              cpu_resetn,
  output logic              boot_done,
  output logic              boot_error
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [LEN_W:0]    MAX_WORDS = (LEN_W + 1)'(2**(ADDR_W - 2));
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYC - 1);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t ST_TAIL = ST_CSUM;
`else
  localparam boot_state_t ST_TAIL = ST_DONE;
`endif

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_frame_err;
  boot_state_t      state;
  logic             skid_full;
  logic [7:0]       skid_data;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] words_left;
  logic [1:0]       byte_idx;
  logic [31:0]      idle_cnt;
  logic             take;
  logic             active;
  logic             overrun;
  logic             timed_out;
  logic             fault;
  logic             sync_seen;
  logic [LEN_W-1:0] len_word;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk          (clk),
    .reset_async  (reset_async),
    .rxd          (rs232_dce_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  // The skid is drained in every state except WRITE, so only a stalled write can overrun it
  assign take      = skid_full && (state != ST_WRITE);
  assign active    = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_DATA) ||
                     (state == ST_WRITE) || (state == ST_CSUM);
  assign overrun   = rx_valid && skid_full && !take;
  assign timed_out = active && (idle_cnt == TO_LAST);
  assign fault     = active && (overrun || rx_frame_err || timed_out);
  assign sync_seen = take && (skid_data == SYNC_BYTE);
  assign len_word  = {skid_data, len_lo};

  assign mem_valid  = (state == ST_WRITE);
  assign mem_wstrb  = mem_valid ? 4'hF : 4'h0;
  assign cpu_resetn = (state == ST_DONE);
  assign boot_done  = (state == ST_DONE);
  assign boot_error = (state == ST_ERROR);

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (rx_valid) begin
      skid_full <= 1'b1;
      skid_data <= rx_data;
    end else if (take) begin
      skid_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      idle_cnt <= '0;
    end else if (!active || rx_valid || rx_frame_err) begin
      idle_cnt <= '0;
    end else if (!timed_out) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      csum <= '0;
    end else if ((state == ST_IDLE || state == ST_ERROR) && sync_seen) begin
      csum <= '0;
    end else if (take && (state == ST_LEN0 || state == ST_LEN1 || state == ST_DATA)) begin
      csum <= csum + skid_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      state      <= ST_IDLE;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (sync_seen) begin
            state    <= ST_LEN0;
            mem_addr <= BASE;
          end
        end
        ST_LEN0: begin
          if (take) begin
            len_lo <= skid_data;
            state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (take) begin
            if ({1'b0, len_word} > MAX_WORDS) begin
              state <= ST_ERROR;
            end else if (len_word == '0) begin
              state <= ST_TAIL;
            end else begin
              words_left <= len_word;
              byte_idx   <= '0;
              state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (take) begin
            mem_wdata[{byte_idx, 3'b000} +: 8] <= skid_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            mem_addr   <= mem_addr + ADDR_W'(WORD_BYTES);
            words_left <= words_left - LEN_W'(1);
            state      <= (words_left == LEN_W'(1)) ? ST_TAIL : ST_DATA;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (take) state <= (skid_data == csum) ? ST_DONE : ST_ERROR;
        end
`endif
        default: ;
      endcase
      if (fault) state <= ST_ERROR;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_boot_loader : scoreboard bench for the UART boot loader
// Rev 1.0
// ============================================================================
module tb_uart_boot_loader;

  localparam int          CLK_HZ = 1_000_000;
  localparam int          BAUD   = 100_000;
  localparam int          DIV    = 10;
  localparam int          TO_CYC = 400;
  localparam logic [14:0] BASE   = 15'h100;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_async = 1'b0;
  logic        rxd = 1'b1;
  logic        mem_ready = 1'b1;
  logic        mem_valid;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpu_resetn;
  logic        boot_done;
  logic        boot_error;

  wr_t         exp_q[$];
  logic [31:0] img [0:1];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          wstarts = 0;
  int          hs_cyc = -1;
  int          done_cyc = -1;
  int          ws0;

  uart_boot_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .ADDR_W      (15),
    .BASE_ADDR   (32'h100),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk           (clk),
    .reset_async   (reset_async),
    .rs232_dce_rxd (rxd),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .cpu_resetn    (cpu_resetn),
    .boot_done     (boot_done),
    .boot_error    (boot_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: scoreboard pops on each handshake, stall stability, done/cpu_resetn alignment
  logic        stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_done = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    wr_t e;
    if (mem_valid && !prev_valid) wstarts++;
    if (stall && mem_valid) begin
      check("hold_addr", 48'(mem_addr), 48'(prev_addr));
      check("hold_data", 48'(mem_wdata), 48'(prev_data));
    end
    if (mem_valid && mem_ready) begin
      hs_cyc = cyc;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '1;
      check("wr_addr", 48'(mem_addr), 48'(e.addr));
      check("wr_data", 48'(mem_wdata), 48'(e.data));
      check("wr_strb", 48'(mem_wstrb), 48'hF);
    end
    if (boot_done !== prev_done) begin
      check("cpu_resetn_vs_done", 48'(cpu_resetn), 48'(boot_done));
      if (boot_done) done_cyc = cyc;
    end
    stall      = mem_valid && !mem_ready;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
    prev_valid = mem_valid;
    prev_done  = boot_done;
  end

  task automatic apply_reset();
    reset_async = 1'b0;
    repeat (3) @(negedge clk);
    reset_async = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_header(input logic [15:0] len);
    send_byte(8'hA5, 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] csum_adj, input bit push);
    logic [7:0] cs;
    logic [7:0] b;
    cs = len[7:0] + len[15:8];
    send_header(len);
    for (int w = 0; w < int'(len); w++) begin
      if (push) exp_q.push_back({BASE + 15'(4 * w), img[w]});
      for (int k = 0; k < 4; k++) begin
        b  = img[w][8*k +: 8];
        cs = cs + b;
        send_byte(b, 1'b1);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(cs + csum_adj, 1'b1);
`else
    if (csum_adj != 8'd0) send_byte(8'h00, 1'b1);
`endif
  endtask

  task automatic wait_status(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (boot_done || boot_error) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;

    apply_reset();
    check("rst_mem_valid", 48'(mem_valid), 48'd0);
    check("rst_mem_addr", 48'(mem_addr), 48'(BASE));
    check("rst_mem_wdata", 48'(mem_wdata), 48'd0);
    check("rst_mem_wstrb", 48'(mem_wstrb), 48'd0);
    check("rst_cpu_resetn", 48'(cpu_resetn), 48'd0);
    check("rst_boot_done", 48'(boot_done), 48'd0);
    check("rst_boot_error", 48'(boot_error), 48'd0);

    // Noise in IDLE, including a framing-error byte
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b0);
    check("noise_error", 48'(boot_error), 48'd0);
    check("noise_writes", 48'(wstarts), 48'd0);

    // Good two-word image
    send_frame(16'd2, 8'd0, 1'b1);
    wait_status(3000);
    check("good_done", 48'(boot_done), 48'd1);
    check("good_cpu_resetn", 48'(cpu_resetn), 48'd1);
    check("good_error", 48'(boot_error), 48'd0);
    check("good_q_empty", 48'(exp_q.size()), 48'd0);
`ifndef BOOT_CHECKSUM_EN
    check("done_latency", 48'(done_cyc), 48'(hs_cyc + 1));
`endif

    // DONE ignores further traffic
    ws0 = wstarts;
    send_header(16'd1);
    repeat (20) @(negedge clk);
    check("done_sticky", 48'(boot_done), 48'd1);
    check("done_no_write", 48'(wstarts - ws0), 48'd0);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum then retry without reset
    apply_reset();
    send_frame(16'd2, 8'd1, 1'b1);
    wait_status(3000);
    check("badcs_error", 48'(boot_error), 48'd1);
    check("badcs_cpu_resetn", 48'(cpu_resetn), 48'd0);
    check("badcs_done", 48'(boot_done), 48'd0);
    check("badcs_q_empty", 48'(exp_q.size()), 48'd0);
    send_frame(16'd2, 8'd0, 1'b1);
    wait_status(3000);
    check("retry_done", 48'(boot_done), 48'd1);
    check("retry_error", 48'(boot_error), 48'd0);
`endif

    // LEN = 0
    apply_reset();
    ws0 = wstarts;
    send_frame(16'd0, 8'd0, 1'b0);
    wait_status(2000);
    check("len0_done", 48'(boot_done), 48'd1);
    check("len0_writes", 48'(wstarts - ws0), 48'd0);

    // Stalled write: one byte parks in the skid, the next overruns
    apply_reset();
    mem_ready = 1'b0;
    send_header(16'd2);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b1);
    for (int i = 0; i < 300 && !mem_valid; i++) @(negedge clk);
    check("stall_valid", 48'(mem_valid), 48'd1);
    check("stall_addr", 48'(mem_addr), 48'(BASE));
    check("stall_data", 48'(mem_wdata), 48'(img[0]));
    send_byte(8'hEF, 1'b1);
    check("skid_no_error", 48'(boot_error), 48'd0);
    check("skid_valid", 48'(mem_valid), 48'd1);
    send_byte(8'hBE, 1'b1);
    wait_status(500);
    check("overrun_error", 48'(boot_error), 48'd1);
    check("overrun_valid", 48'(mem_valid), 48'd0);
    mem_ready = 1'b1;

    // Recovery from ERROR by a fresh sync byte
    send_frame(16'd2, 8'd0, 1'b1);
    wait_status(3000);
    check("recover_done", 48'(boot_done), 48'd1);
    check("recover_error", 48'(boot_error), 48'd0);

    // Reset while a write is pending
    apply_reset();
    mem_ready = 1'b0;
    send_header(16'd1);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b1);
    check("midrst_pre_valid", 48'(mem_valid), 48'd1);
    reset_async = 1'b0;
    @(negedge clk);
    check("midrst_valid", 48'(mem_valid), 48'd0);
    check("midrst_addr", 48'(mem_addr), 48'(BASE));
    reset_async = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Oversize length
    apply_reset();
    ws0 = wstarts;
    send_header(16'h2001);
    wait_status(500);
    check("oversize_error", 48'(boot_error), 48'd1);
    check("oversize_writes", 48'(wstarts - ws0), 48'd0);

    // Largest legal length is accepted
    apply_reset();
    send_header(16'h2000);
    repeat (50) @(negedge clk);
    check("maxlen_no_error", 48'(boot_error), 48'd0);

    // Timeout after three data bytes
    apply_reset();
    ws0 = wstarts;
    send_header(16'd1);
    for (int k = 0; k < 3; k++) send_byte(img[0][8*k +: 8], 1'b1);
    check("pre_timeout_error", 48'(boot_error), 48'd0);
    wait_status(TO_CYC + 200);
    check("timeout_error", 48'(boot_error), 48'd1);
    check("timeout_writes", 48'(wstarts - ws0), 48'd0);

    // Framing error on LEN_LO
    apply_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b0);
    wait_status(300);
    check("frame_err_error", 48'(boot_error), 48'd1);
    check("frame_err_done", 48'(boot_done), 48'd0);

    check("final_q_empty", 48'(exp_q.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial firmware loader sitting directly upstream of the chip's 32 KiB program RAM (eight 4 KiB×32 banks) and of the CPU reset. It receives a framed image on `rs232_dce_rxd`, assembles little-endian 32-bit words and writes them through a valid/ready write port into RAM from `BASE_ADDR` upward. It holds the CPU in reset until a complete, checksum-clean image has been written.

## Interface
- `CLK_HZ`, 50000000: core clock frequency.
- `BAUD`, 115200: serial bit rate; divisor `DIV = (CLK_HZ + BAUD/2) / BAUD`.
- `ADDR_W`, 15: byte-address width of the RAM window (32 KiB).
- `BASE_ADDR`, 0: byte address of the first word written; word-aligned.
- `TIMEOUT_CYC`, 2**24: maximum idle cycles between bytes once a frame has started.

- `clk`  in  1  core clock.
- `reset_async`  in  1  asynchronous, active-low reset.
- `rs232_dce_rxd`  in  1  serial input, idle high, 8N1.
- `mem_valid`  out  1  write request.
- `mem_ready`  in  1  RAM accepts the write in this cycle.
- `mem_addr`  out  ADDR_W  byte address, word-aligned.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  always 4'hF while `mem_valid` is high, else 0.
- `cpu_resetn`  out  1  CPU reset, active-low.
- `boot_done`  out  1  image loaded successfully.
- `boot_error`  out  1  last frame failed: framing error, overrun, timeout, oversize or checksum mismatch.

## Operation
- Frame format: `0xA5`, `LEN_LO`, `LEN_HI`, then LEN words of 4 bytes each (LSB first), then `CSUM`. CSUM is the 8-bit sum of LEN_LO, LEN_HI and all data bytes.
- FSM states and transitions:
  - IDLE: waits for byte `0xA5`; other bytes are ignored.
  - LEN0, LEN1: capture LEN.
  - DATA: advances on each byte; `byte_idx` counts 0..3.
  - WRITE: after the 4th byte; holds `mem_valid` until `mem_ready`.
  - CSUM.
  - DONE.
  - ERROR.
- LEN > 2**(ADDR_W-2) → ERROR immediately after LEN1.
- LEN = 0 → LEN1 goes straight to CSUM.
- WRITE: the address increments by 4 on handshake. Return to DATA, or to CSUM after the last word.
- CSUM match → DONE, otherwise → ERROR.
- DONE: `boot_done=1`, `cpu_resetn=1`. Further serial bytes are ignored until reset.
- ERROR: `boot_error=1`, `cpu_resetn=0`. A new `0xA5` clears `boot_error` and restarts at LEN0 with the address reloaded to BASE_ADDR.
- One-byte skid register between the receiver and the FSM, so a byte arriving during WRITE is held. If a byte arrives while the skid is full → overrun → ERROR.
- Framing error (stop bit = 0): the byte is discarded. In IDLE the FSM stays in IDLE; in any other non-DONE state → ERROR.
- Timeout: the counter resets on each received byte and is active only in LEN0..CSUM. Reaching TIMEOUT_CYC → ERROR.

## Timing
- Reset values: `mem_valid=0`, `mem_addr=BASE_ADDR`, `mem_wdata=0`, `mem_wstrb=0`, `cpu_resetn=0`, `boot_done=0`, `boot_error=0`; FSM in IDLE.
- `rs232_dce_rxd` is double-flop synchronised; this adds 2 cycles of latency.
- Receiver:
  - Start is detected on a synchronised falling edge, then re-checked low at DIV/2.
  - Data and stop bits are sampled at DIV intervals after that.
  - `rx_valid` pulses for 1 cycle at the stop-bit sample.
- `mem_valid` rises the cycle after the 4th data byte is taken from the skid. Addr, data and strobe stay stable until the `mem_ready` cycle; `mem_valid` drops the next cycle.
- `cpu_resetn` and `boot_done` rise in the same cycle, the cycle after CSUM is consumed.
- Reset mid-frame: everything returns to reset values, and any in-flight `mem_valid` is dropped without completing.

## Configuration
- `BOOT_CHECKSUM_EN` defined: the CSUM byte is required and checked as above.
- Undefined: no CSUM byte; DONE is entered the cycle after the final write handshake (or after LEN1 when LEN=0). Checksum logic is removed and mismatch cannot cause ERROR.

## Structure
- Shared package `boot_pkg`: FSM state enum, `SYNC_BYTE = 8'hA5`, and the frame-field constants.
- Sub-module `uart_rx` (parameters CLK_HZ, BAUD; outputs `rx_data[7:0]`, `rx_valid`, `rx_frame_err`). The top contains the skid register, FSM, address counter, checksum and timeout.

## Test plan
- Frame A5 02 00 | 78 56 34 12 | EF BE AD DE | CSUM=0x??, with `mem_ready` tied high → writes 0x12345678 @0 and 0xDEADBEEF @4. Then `boot_done=1`, `cpu_resetn=1`, `boot_error=0`.
- Same frame with CSUM off by one → two writes occur, then `boot_error=1`, `cpu_resetn=0`. Resending the correct frame → `boot_done=1`.
- `mem_ready` held low 10000 cycles during the first write while the next bytes stream in → `mem_valid` stays asserted with stable addr/data. The next byte is held in the skid; a second byte arriving meanwhile → overrun → `boot_error=1`.
- LEN = 0x2001 (exceeds 8192 words) → ERROR after LEN_HI, with no `mem_valid` pulses.
- Frame stalls after 3 data bytes for TIMEOUT_CYC cycles → `boot_error=1`, no write issued.
- Stop bit forced 0 on LEN_LO → ERROR. Noise bytes 0x00/0xFF in IDLE → no state change. Without `BOOT_CHECKSUM_EN`: A5 01 00 + 4 data bytes → `boot_done` one cycle after the handshake.
